tug_light_bar: RTL and testbench

- Parametrised successor to the single-position playfield light.
- Holds a one-hot light position across N_LIGHTS LEDs. Player L and R button presses pull the light toward their own end.
- Detects a round win and keeps a saturating per-player score. Declares match-over when either score reaches SCORE_MAX.
- Sits between the button input conditioners and the LED/HEX display drivers in the game top level.

---
 rtl/tug_light_bar_if.sv | 28 ++
 rtl/tug_light_bar.sv | 119 +++++++++++
 tb/tb_tug_light_bar.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/tug_light_bar_if.sv
// Signal bundle between the button conditioners, the tug-of-war light bar and
// the LED/HEX display drivers.
interface tug_light_bar_if #(
   parameter int N_LIGHTS = 9,
   parameter int SCORE_W  = 3
);
   // No valid/ready pair: newGame, L and R are synchronised levels sampled
   // every clk; all outputs are registered and valid every cycle after reset.
   logic                newGame;
   logic                L;
   logic                R;
   logic [N_LIGHTS-1:0] lights;
   logic [1:0]          winner;
   logic [SCORE_W-1:0]  scoreL;
   logic [SCORE_W-1:0]  scoreR;
   logic                matchOver;
   logic [1:0]          dbg_state;

   modport master (
      output newGame, L, R,
      input  lights, winner, scoreL, scoreR, matchOver, dbg_state
   );

   modport slave (
      input  newGame, L, R,
      output lights, winner, scoreL, scoreR, matchOver, dbg_state
   );
endinterface

// File: rtl/tug_light_bar.sv
// Tug-of-war playfield: one-hot light pulled left/right by button presses,
// with round-win detection, saturating scores and match-over.
module tug_light_bar #(
   parameter int N_LIGHTS  = 9,
   parameter int SCORE_W   = 3,
   parameter int SCORE_MAX = 7
) (
   input logic            clk,
   input logic            Reset,
   tug_light_bar_if.slave bus
);
   localparam int PW = $clog2(N_LIGHTS);
   localparam logic [PW-1:0]       CENTER = PW'(N_LIGHTS / 2);
   localparam logic [PW-1:0]       LEFT_END = PW'(N_LIGHTS - 1);
   localparam logic [SCORE_W-1:0]  SMAX = SCORE_W'(SCORE_MAX);
   localparam logic [N_LIGHTS-1:0] ONE = N_LIGHTS'(1);

   typedef enum logic [1:0] {
      S_PLAY  = 2'd0,
      S_WIN_L = 2'd1,
      S_WIN_R = 2'd2,
      S_MATCH = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       pos_q, pos_d;
   logic [SCORE_W-1:0]  score_l_q, score_l_d;
   logic [SCORE_W-1:0]  score_r_q, score_r_d;
   logic [1:0]          winner_q, winner_d;
   logic [N_LIGHTS-1:0] lights_q, lights_d;
   logic                match_q, match_d;
   logic                l_q, r_q;

   logic press_l, press_r, mv_l, mv_r;

   assign press_l = bus.L & ~l_q;
   assign press_r = bus.R & ~r_q;
   assign mv_l    = press_l & ~press_r;
   assign mv_r    = press_r & ~press_l;

   // Button history loads even during Reset so a button held through reset
   // never produces a press.
   always_ff @(posedge clk) begin
      l_q <= bus.L;
      r_q <= bus.R;
      if (Reset) begin
         state_q   <= S_PLAY;
         pos_q     <= CENTER;
         score_l_q <= '0;
         score_r_q <= '0;
         winner_q  <= 2'b00;
         lights_q  <= ONE << CENTER;
         match_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
         winner_q  <= winner_d;
         lights_q  <= lights_d;
         match_q   <= match_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      score_l_d = score_l_q;
      score_r_d = score_r_q;
      winner_d  = winner_q;

      unique case (state_q)
         S_PLAY: begin
            if (bus.newGame) begin
               pos_d = CENTER;
            end else if (mv_l) begin
               if (pos_q == LEFT_END) begin
                  if (score_l_q != SMAX) score_l_d = score_l_q + SCORE_W'(1);
                  winner_d = 2'b10;
                  state_d  = (score_l_d == SMAX) ? S_MATCH : S_WIN_L;
               end else begin
                  pos_d = pos_q + PW'(1);
               end
            end else if (mv_r) begin
               if (pos_q == '0) begin
                  if (score_r_q != SMAX) score_r_d = score_r_q + SCORE_W'(1);
                  winner_d = 2'b01;
                  state_d  = (score_r_d == SMAX) ? S_MATCH : S_WIN_R;
               end else begin
                  pos_d = pos_q - PW'(1);
               end
            end
         end
         S_WIN_L, S_WIN_R: begin
            if (bus.newGame) begin
               pos_d    = CENTER;
               winner_d = 2'b00;
               state_d  = S_PLAY;
            end
         end
         S_MATCH: begin
            state_d = S_MATCH;
         end
         default: begin
            state_d = S_PLAY;
         end
      endcase

      lights_d = (state_d == S_PLAY) ? (ONE << pos_d) : '0;
      match_d  = (state_d == S_MATCH);
   end

   assign bus.lights    = lights_q;
   assign bus.winner    = winner_q;
   assign bus.scoreL    = score_l_q;
   assign bus.scoreR    = score_r_q;
   assign bus.matchOver = match_q;
   assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_tug_light_bar.sv
// Bench for tug_light_bar: two instances (SCORE_MAX 7 and 2) driven in lockstep
// and checked every cycle against a behavioural game model.
module tb_tug_light_bar;
   localparam int N  = 9;
   localparam int W  = 3;
   localparam int CTR = N / 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   tug_light_bar_if #(.N_LIGHTS(N), .SCORE_W(W)) if_a ();
   tug_light_bar_if #(.N_LIGHTS(N), .SCORE_W(W)) if_b ();

   tug_light_bar #(.N_LIGHTS(N), .SCORE_W(W), .SCORE_MAX(7)) dut_a (
      .clk   (clk),
      .Reset (rst),
      .bus   (if_a.slave)
   );

   tug_light_bar #(.N_LIGHTS(N), .SCORE_W(W), .SCORE_MAX(2)) dut_b (
      .clk   (clk),
      .Reset (rst),
      .bus   (if_b.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Expected {lights, winner, scoreL, scoreR, matchOver}; instance a then b.
   logic [N+8:0] exp_q[$];

   // Model: mode 0 = round in play, 1 = round over, 2 = match over.
   int   smax[2] = '{7, 2};
   int   m_pos[2], m_mode[2], m_win[2], m_sl[2], m_sr[2];
   logic m_pl[2], m_pr[2];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_step(input logic l, input logic r, input logic ng, input logic rs);
      logic         pl, pr, ml, mr;
      logic [N-1:0] lv;
      for (int m = 0; m < 2; m++) begin
         pl = l & ~m_pl[m];
         pr = r & ~m_pr[m];
         ml = pl & ~pr;
         mr = pr & ~pl;
         m_pl[m] = l;
         m_pr[m] = r;
         if (rs) begin
            m_mode[m] = 0; m_pos[m] = CTR; m_win[m] = 0; m_sl[m] = 0; m_sr[m] = 0;
         end else if (m_mode[m] == 0) begin
            if (ng) begin
               m_pos[m] = CTR;
            end else if (ml) begin
               if (m_pos[m] == N - 1) begin
                  if (m_sl[m] < smax[m]) m_sl[m]++;
                  m_win[m]  = 2;
                  m_mode[m] = (m_sl[m] == smax[m]) ? 2 : 1;
               end else begin
                  m_pos[m]++;
               end
            end else if (mr) begin
               if (m_pos[m] == 0) begin
                  if (m_sr[m] < smax[m]) m_sr[m]++;
                  m_win[m]  = 1;
                  m_mode[m] = (m_sr[m] == smax[m]) ? 2 : 1;
               end else begin
                  m_pos[m]--;
               end
            end
         end else if (m_mode[m] == 1 && ng) begin
            m_mode[m] = 0; m_pos[m] = CTR; m_win[m] = 0;
         end
         lv = '0;
         if (m_mode[m] == 0) lv[m_pos[m]] = 1'b1;
         exp_q.push_back({lv, 2'(m_win[m]), 3'(m_sl[m]), 3'(m_sr[m]), (m_mode[m] == 2)});
      end
   endtask

   task automatic cmp_one(input string who, input logic [N-1:0] li, input logic [1:0] wi,
                          input logic [W-1:0] sl, input logic [W-1:0] sr, input logic mo);
      logic [N+8:0] e;
      if (exp_q.size() == 0) begin
         check_eq({who, ".queue_empty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check_eq({who, ".lights"}, 32'(li), 32'(e[N+8:9]));
         check_eq({who, ".winner"}, 32'(wi), 32'(e[8:7]));
         check_eq({who, ".scoreL"}, 32'(sl), 32'(e[6:4]));
         check_eq({who, ".scoreR"}, 32'(sr), 32'(e[3:1]));
         check_eq({who, ".matchOver"}, 32'(mo), 32'(e[0]));
      end
   endtask

   // Called from a negedge: drive, take one active edge, check at next negedge.
   task automatic cycle(input logic l, input logic r, input logic ng, input logic rs);
      rst = rs;
      if_a.L = l; if_a.R = r; if_a.newGame = ng;
      if_b.L = l; if_b.R = r; if_b.newGame = ng;
      @(posedge clk);
      model_step(l, r, ng, rs);
      @(negedge clk);
      cmp_one("a", if_a.lights, if_a.winner, if_a.scoreL, if_a.scoreR, if_a.matchOver);
      cmp_one("b", if_b.lights, if_b.winner, if_b.scoreL, if_b.scoreR, if_b.matchOver);
   endtask

   task automatic pulse(input logic l, input logic r);
      cycle(l, r, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      for (int m = 0; m < 2; m++) begin
         m_pos[m] = CTR; m_mode[m] = 0; m_win[m] = 0; m_sl[m] = 0; m_sr[m] = 0;
         m_pl[m] = 1'b0; m_pr[m] = 1'b0;
      end
      rst = 1'b1;
      if_a.L = 1'b0; if_a.R = 1'b0; if_a.newGame = 1'b0;
      if_b.L = 1'b0; if_b.R = 1'b0; if_b.newGame = 1'b0;
      @(negedge clk);

      // Reset with L held, then L held after release: no move.
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("reset_lights", 32'(if_a.lights), 32'h010);
      check_eq("reset_winner", 32'(if_a.winner), 32'h0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("held_l_no_move", 32'(if_a.lights), 32'h010);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // Four steps to the left end, fifth press wins the round.
      pulse(1'b1, 1'b0);
      check_eq("step1", 32'(if_a.lights), 32'h020);
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      check_eq("step4", 32'(if_a.lights), 32'h100);
      pulse(1'b1, 1'b0);
      check_eq("winl_lights", 32'(if_a.lights), 32'h0);
      check_eq("winl_winner", 32'(if_a.winner), 32'h2);
      check_eq("winl_score", 32'(if_a.scoreL), 32'h1);

      // Presses ignored in WIN_L; newGame restarts with score retained.
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      check_eq("winl_ignore_r", 32'(if_a.winner), 32'h2);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("newgame_lights", 32'(if_a.lights), 32'h010);
      check_eq("newgame_winner", 32'(if_a.winner), 32'h0);
      check_eq("newgame_scorel", 32'(if_a.scoreL), 32'h1);

      // Simultaneous presses cancel at pos 6.
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      check_eq("pos6", 32'(if_a.lights), 32'h040);
      pulse(1'b1, 1'b1);
      check_eq("both_cancel", 32'(if_a.lights), 32'h040);
      pulse(1'b0, 1'b1);
      check_eq("r_after_both", 32'(if_a.lights), 32'h020);

      // newGame beats a same-cycle press at pos 2.
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      check_eq("pos2", 32'(if_a.lights), 32'h004);
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      check_eq("ng_priority", 32'(if_a.lights), 32'h010);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // Right wins twice: instance b reaches SCORE_MAX=2.
      for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1);
      check_eq("b_winr_score", 32'(if_b.scoreR), 32'h1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1);
      check_eq("b_match_score", 32'(if_b.scoreR), 32'h2);
      check_eq("b_match_over", 32'(if_b.matchOver), 32'h1);
      check_eq("b_match_winner", 32'(if_b.winner), 32'h1);
      check_eq("a_not_match", 32'(if_a.matchOver), 32'h0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("b_match_ng_ignored", 32'(if_b.matchOver), 32'h1);
      check_eq("b_match_lights", 32'(if_b.lights), 32'h0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("b_reset_score", 32'(if_b.scoreR), 32'h0);
      check_eq("b_reset_lights", 32'(if_b.lights), 32'h010);
      check_eq("b_reset_match", 32'(if_b.matchOver), 32'h0);

      // Randomised play against the model.
      for (int i = 0; i < 2000; i++) begin
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 249) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
